// File: rtl/dm_pkg.sv
// Shared constants and FSM state encoding for the data-memory responder.
// Defaults match a 16-bit CPU with a 256-word data memory and two wait states.
// Imported by dm_responder and dm_ram.
package dm_pkg;
  localparam int DM_DATA_W   = 16;
  localparam int DM_ADDR_W   = 16;
  localparam int DM_DEPTH    = 256;
  localparam int DM_WAIT_CYC = 2;
  // Wait counter wide enough for the largest legal wait-state count (15)
  localparam int DM_CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_t;
endpackage

// File: rtl/dm_ram.sv
// Word storage: synchronous write, combinational read on one shared index.
// Read data follows the index within the same cycle; write lands at the clock edge.
// No flow control; the caller decides when a write is allowed.
module dm_ram
  import dm_pkg::*;
#(
  parameter int DATA_W = DM_DATA_W,
  parameter int DEPTH  = DM_DEPTH,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Store path; contents are never cleared, so reset leaves memory intact
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dm_responder.sv
// Memory-side responder: accepts one CPU access, waits WAIT_CYC cycles, then acks.
// Latency WAIT_CYC+1 cycles from acceptance to the one-cycle ACK pulse.
// New requests are only taken in IDLE; REQ is ignored while an access is in flight.
module dm_responder
  import dm_pkg::*;
#(
  parameter int DATA_W   = DM_DATA_W,
  parameter int ADDR_W   = DM_ADDR_W,
  parameter int DEPTH    = DM_DEPTH,
  parameter int WAIT_CYC = DM_WAIT_CYC
) (
  input  logic              CLK,
  input  logic              START,
  input  logic              REQ,
  input  logic              WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] WDATA,
  output logic              ACK,
  output logic [DATA_W-1:0] RDATA,
  output logic              BUSY,
  output logic              ERR
);

  localparam int IDX_W = $clog2(DEPTH);
  // One extra bit so a DEPTH equal to 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH);

  dm_state_t           r_state;
  logic [DM_CNT_W-1:0] r_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_ack;
  logic                r_busy;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;

  logic [ADDR_W-1:0]   w_addr;
  logic                w_oor;
  logic                w_wr;
  logic [DATA_W-1:0]   w_mem_rdata;
  logic [DATA_W-1:0]   w_load_dat;

  // In IDLE the live address is used so a zero-wait access can respond in the next cycle
  assign w_addr     = (r_state == IDLE) ? ADDR : r_addr;
  assign w_oor      = ({1'b0, w_addr} >= LIM);
  assign w_load_dat = w_oor ? '0 : w_mem_rdata;
  // Store commits at the edge ending RESP, unless out of range or aborted by reset
  assign w_wr       = (r_state == RESP) && r_we && !w_oor && !START;

  dm_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .i_clk   (CLK),
    .i_we    (w_wr),
    .i_idx   (w_addr[IDX_W-1:0]),
    .i_wdata (r_wdata),
    .o_rdata (w_mem_rdata)
  );

  // Accept, count wait states, pulse ACK with registered ERR/RDATA, return to IDLE
  always_ff @(posedge CLK) begin
    if (START) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ack <= 1'b0;
          r_err <= 1'b0;
          if (REQ) begin
            r_we    <= WE;
            r_addr  <= ADDR;
            r_wdata <= WDATA;
            r_cnt   <= DM_CNT_W'(WAIT_CYC);
            r_busy  <= 1'b1;
            if (WAIT_CYC == 0) begin
              r_state <= RESP;
              r_ack   <= 1'b1;
              r_err   <= w_oor;
              if (!WE) r_rdata <= w_load_dat;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == DM_CNT_W'(1)) begin
            r_state <= RESP;
            r_ack   <= 1'b1;
            r_err   <= w_oor;
            if (!r_we) r_rdata <= w_load_dat;
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ACK   = r_ack;
  assign BUSY  = r_busy;
  assign ERR   = r_err;
  assign RDATA = r_rdata;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench: two responders (2 wait states and 0 wait states) checked
// against a word-level memory model with directed and randomized accesses.
module tb_dm_responder;
  localparam int P = 10;

  logic CLK = 1'b0;
  always #(P/2) CLK = ~CLK;

  logic        START, REQ2, REQ0, WE;
  logic [15:0] ADDR, WDATA;
  logic        ACK2, BUSY2, ERR2, ACK0, BUSY0, ERR0;
  logic [15:0] RDATA2, RDATA0;

  dm_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYC(2)) dut2 (
    .CLK(CLK), .START(START), .REQ(REQ2), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
    .ACK(ACK2), .RDATA(RDATA2), .BUSY(BUSY2), .ERR(ERR2));

  dm_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYC(0)) dut0 (
    .CLK(CLK), .START(START), .REQ(REQ0), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
    .ACK(ACK0), .RDATA(RDATA0), .BUSY(BUSY0), .ERR(ERR0));

  int checks = 0;
  int errors = 0;

  // Reference model: one word map per responder plus the RDATA each should hold
  logic [15:0] mem2 [int];
  logic [15:0] mem0 [int];
  logic [15:0] rd_exp2 = '0;
  logic [15:0] rd_exp0 = '0;
  time         last_ack = 0;
  bit          prev_hold = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input bit d0, output logic a, output logic b, output logic e,
                        output logic [15:0] r);
    if (d0) begin a = ACK0; b = BUSY0; e = ERR0; r = RDATA0; end
    else    begin a = ACK2; b = BUSY2; e = ERR2; r = RDATA2; end
  endtask

  // One access on the chosen responder, starting at a negedge of an IDLE cycle.
  // hold=1 keeps REQ high past ACK so the next call chains back-to-back.
  task automatic acc(input string tag, input bit d0, input logic we,
                     input logic [15:0] addr, input logic [15:0] wd, input bit hold);
    int          w;
    bit          oor;
    logic [15:0] exp_rd;
    logic        a, b, e;
    logic [15:0] r;
    w      = d0 ? 0 : 2;
    oor    = (addr >= 16'd256);
    exp_rd = d0 ? rd_exp0 : rd_exp2;
    if (!we) begin
      if (oor)     exp_rd = '0;
      else if (d0) exp_rd = mem0[int'(addr)];
      else         exp_rd = mem2[int'(addr)];
    end
    WE = we; ADDR = addr; WDATA = wd;
    if (d0) REQ0 = 1'b1; else REQ2 = 1'b1;
    for (int k = 1; k <= w + 1; k++) begin
      @(negedge CLK);
      sample(d0, a, b, e, r);
      chk({tag, ".busy"}, 32'(b), 32'(1));
      chk({tag, ".ack"},  32'(a), 32'(k == w + 1));
      chk({tag, ".err"},  32'(e), 32'((k == w + 1) && oor));
      if (k == w + 1) begin
        chk({tag, ".rdata"}, 32'(r), 32'(exp_rd));
        if (prev_hold) chk({tag, ".spacing"}, 32'($time - last_ack), 32'((w + 2) * P));
        last_ack = $time;
        if (!hold) begin REQ0 = 1'b0; REQ2 = 1'b0; end
      end else if (k == 1) begin
        // Inputs wander while the access is in flight; the latched request must not care
        WE = 1'($urandom); ADDR = 16'($urandom); WDATA = 16'($urandom);
      end
    end
    prev_hold = hold;
    if (we && !oor) begin
      if (d0) mem0[int'(addr)] = wd; else mem2[int'(addr)] = wd;
    end
    if (d0) rd_exp0 = exp_rd; else rd_exp2 = exp_rd;
    @(negedge CLK);
    sample(d0, a, b, e, r);
    chk({tag, ".idle_ack"},  32'(a), 32'(0));
    chk({tag, ".idle_busy"}, 32'(b), 32'(0));
    chk({tag, ".idle_err"},  32'(e), 32'(0));
    chk({tag, ".idle_rd"},   32'(r), 32'(exp_rd));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".ack"},   32'(ACK2),   32'(0));
    chk({tag, ".busy"},  32'(BUSY2),  32'(0));
    chk({tag, ".err"},   32'(ERR2),   32'(0));
    chk({tag, ".rdata"}, 32'(RDATA2), 32'(0));
    chk({tag, ".rd0"},   32'(RDATA0), 32'(0));
  endtask

  logic [15:0] pool [8] = '{16'h0000, 16'h0001, 16'h0002, 16'h0005,
                            16'h0007, 16'h0009, 16'h0080, 16'h00FF};

  initial begin
    bit          d;
    logic        rwe;
    logic [15:0] ra;

    // Reset with REQ asserted: nothing may be accepted
    START = 1'b1; REQ2 = 1'b1; REQ0 = 1'b1; WE = 1'b1; ADDR = '0; WDATA = '0;
    repeat (3) begin
      @(negedge CLK);
      chk_reset_outputs("reset");
    end
    REQ0 = 1'b0;
    START = 1'b0;

    // Store then load at 0x0005; first store is accepted at the first edge out of reset
    acc("st5", 0, 1'b1, 16'h0005, 16'hBEEF, 0);
    acc("ld5", 0, 1'b0, 16'h0005, 16'h0000, 0);
    repeat (3) begin
      @(negedge CLK);
      chk("ld5.hold_rd", 32'(RDATA2), 32'(16'hBEEF));
      chk("ld5.hold_ack", 32'(ACK2), 32'(0));
    end

    // Out-of-range accesses, including one that would alias onto 0x0005 if truncated
    acc("st0",      0, 1'b1, 16'h0000, 16'h1357, 0);
    acc("st100",    0, 1'b1, 16'h0100, 16'hDEAD, 0);
    acc("ld0",      0, 1'b0, 16'h0000, 16'h0000, 0);
    acc("ld100",    0, 1'b0, 16'h0100, 16'h0000, 0);
    acc("st1005",   0, 1'b1, 16'h1005, 16'h7777, 0);
    acc("ld5alias", 0, 1'b0, 16'h0005, 16'h0000, 0);
    acc("ldFFFF",   0, 1'b0, 16'hFFFF, 16'h0000, 0);

    // REQ held high continuously: one access every WAIT_CYC+2 cycles
    acc("b2b_st1", 0, 1'b1, 16'h0001, 16'h1111, 1);
    acc("b2b_st2", 0, 1'b1, 16'h0002, 16'h2222, 1);
    acc("b2b_ld1", 0, 1'b0, 16'h0001, 16'h0000, 1);
    acc("b2b_ld2", 0, 1'b0, 16'h0002, 16'h0000, 0);

    // Reset during WAIT of a store: no ACK, no write
    acc("st7", 0, 1'b1, 16'h0007, 16'h1111, 0);
    WE = 1'b1; ADDR = 16'h0007; WDATA = 16'h1234; REQ2 = 1'b1;
    @(negedge CLK);
    chk("abort_wait.busy", 32'(BUSY2), 32'(1));
    chk("abort_wait.ack",  32'(ACK2),  32'(0));
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0; REQ2 = 1'b0;
    rd_exp2 = '0; rd_exp0 = '0;
    chk_reset_outputs("abort_wait");
    @(negedge CLK);
    chk("abort_wait.post_ack",  32'(ACK2),  32'(0));
    chk("abort_wait.post_busy", 32'(BUSY2), 32'(0));
    acc("ld7", 0, 1'b0, 16'h0007, 16'h0000, 0);

    // Reset during RESP of a store: the pending write is discarded
    acc("st9", 0, 1'b1, 16'h0009, 16'h2222, 0);
    WE = 1'b1; ADDR = 16'h0009; WDATA = 16'h5555; REQ2 = 1'b1;
    repeat (3) @(negedge CLK);
    chk("abort_resp.ack", 32'(ACK2), 32'(1));
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0; REQ2 = 1'b0;
    rd_exp2 = '0; rd_exp0 = '0;
    chk_reset_outputs("abort_resp");
    acc("ld9", 0, 1'b0, 16'h0009, 16'h0000, 0);

    // Zero wait states: ACK one cycle after acceptance
    acc("z_stFF",  1, 1'b1, 16'h00FF, 16'hA5A5, 0);
    acc("z_ldFF",  1, 1'b0, 16'h00FF, 16'h0000, 0);
    acc("z_ld100", 1, 1'b0, 16'h0100, 16'h0000, 0);
    acc("z_b2b1",  1, 1'b1, 16'h0010, 16'h0F0F, 1);
    acc("z_b2b2",  1, 1'b0, 16'h0010, 16'h0000, 0);

    // Randomized traffic over a pool of known addresses plus occasional out-of-range ones
    for (int i = 0; i < 8; i++) begin
      acc("pre2", 0, 1'b1, pool[i], 16'($urandom), 0);
      acc("pre0", 1, 1'b1, pool[i], 16'($urandom), 0);
    end
    for (int i = 0; i < 60; i++) begin
      d   = 1'($urandom_range(0, 1));
      rwe = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) ra = 16'($urandom_range(256, 65535));
      else                           ra = pool[$urandom_range(0, 7)];
      acc("rnd", d, rwe, ra, 16'($urandom), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width.
REQ-002 SHALL have parameter ADDR_W, default 16, word-address width, matching the CPU ALU result width.
REQ-003 SHALL have parameter DEPTH, default 256, number of storage words.
REQ-004 SHALL have parameter WAIT_CYC, default 2, wait states inserted per access (legal range 0..15).
REQ-005 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port START  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port REQ  input  1  access request from the CPU side; held high until ACK.
REQ-008 SHALL have port WE  input  1  1 = store, 0 = load; sampled with REQ.
REQ-009 SHALL have port ADDR  input  ADDR_W  word address; sampled with REQ.
REQ-010 SHALL have port WDATA  input  DATA_W  store data; sampled with REQ.
REQ-011 SHALL have port ACK  output  1  one-cycle completion pulse.
REQ-012 SHALL have port RDATA  output  DATA_W  load data; valid in the ACK cycle and held until the next load ACK.
REQ-013 SHALL have port BUSY  output  1  high from the cycle after acceptance until ACK inclusive.
REQ-014 SHALL have port ERR  output  1  qualifies ACK; high = address out of range.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-016 SHALL, in IDLE with REQ=1, latch WE, ADDR and WDATA.
REQ-017 SHALL, on that acceptance, load the wait counter with WAIT_CYC.
REQ-018 SHALL, on that acceptance, go to WAIT, or go to RESP if WAIT_CYC=0.
REQ-019 SHALL, in WAIT, decrement the counter each cycle and go to RESP in the cycle after the counter reads 1.
REQ-020 SHALL assert ACK only in RESP, for exactly one cycle, then return to IDLE.
REQ-021 SHALL have latency of exactly WAIT_CYC+1 cycles: accepted at edge N, ACK high during cycle N+WAIT_CYC+1.
REQ-022 SHALL ignore REQ in WAIT and RESP; the latched request is not modified by input changes.
REQ-023 SHALL accept the next request in the first IDLE cycle after ACK; back-to-back throughput is one access per WAIT_CYC+2 cycles.
REQ-024 SHALL, for a store, write the latched WDATA to storage at the clock edge ending the RESP cycle.
REQ-025 SHALL leave RDATA unchanged on a store.
REQ-026 SHALL, for a load, drive RDATA with the storage word at the latched ADDR in the RESP cycle and hold it afterwards.
REQ-027 SHALL, when the latched ADDR is at least DEPTH, suppress any write.
REQ-028 SHALL, for an out-of-range load, drive RDATA=0.
REQ-029 SHALL, for any out-of-range access, assert ERR together with ACK; ERR SHALL be 0 whenever ACK=0.
REQ-030 SHALL compare addresses on the full ADDR_W bits, with no wrap-around or aliasing.
REQ-031 SHALL, for a load that follows a store to the same address, return the stored data.

Reset
REQ-032 SHALL, with START=1 at a clock edge, force state IDLE, counter 0, ACK=0, BUSY=0, ERR=0 and RDATA=0.
REQ-033 SHALL, when START is asserted mid-operation (WAIT or RESP), abort the access and discard any pending store without writing it.
REQ-034 SHALL leave storage contents unchanged under reset, which does not initialise memory.
REQ-035 SHALL ignore REQ during reset and accept a request at the first edge with START=0.

Structure
REQ-036 SHALL take the FSM state enumeration and the default DATA_W, ADDR_W, DEPTH and WAIT_CYC constants from the shared package dm_pkg.
REQ-037 SHALL place the storage array in one sub-module dm_ram (synchronous write, combinational read).
REQ-038 SHALL keep the FSM, counter and request latches in dm_responder.

Verification
REQ-039 SHALL cover: after reset, store ADDR=0x0005, WDATA=0xBEEF, WAIT_CYC=2 -> ACK in the 3rd cycle after acceptance, ERR=0, BUSY high for 3 cycles.
REQ-040 SHALL cover: then load ADDR=0x0005 -> RDATA=0xBEEF in the ACK cycle; RDATA stays 0xBEEF through the following idle cycles.
REQ-041 SHALL cover: store to ADDR=0x0100 (DEPTH=256) -> ACK with ERR=1; a subsequent load of 0x0000 returns its previous contents; a load of 0x0100 returns RDATA=0 with ERR=1.
REQ-042 SHALL cover: REQ held high continuously with ADDR alternating 1, 2 -> accesses complete every 4 cycles; WDATA/ADDR changes during WAIT have no effect.
REQ-043 SHALL cover: START pulsed high in the WAIT cycle of a store 0x0007<-0x1234 -> no ACK; a load of 0x0007 returns its old value; all outputs are 0 in the cycle after reset.
REQ-044 SHALL cover: with WAIT_CYC=0, store then load 0x00FF <- 0xA5A5 -> ACK one cycle after each acceptance, RDATA=0xA5A5.
